// File: rtl/bus_dp_pkg.sv
// Shared encodings for the single-bus datapath: bus sources, ALU ops,
// immediate formats, register selects and the memory FSM state.
package bus_dp_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_IMM  = 3'd1,
    BUS_ALU  = 3'd2,
    BUS_REG  = 3'd3,
    BUS_MEM  = 3'd4
  } bus_src_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_A = 4'd10,
    ALU_PASS_B = 4'd11,
    ALU_ADD4   = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_U = 2'd3
  } imm_sel_e;

  typedef enum logic [2:0] {
    RS_RS1     = 3'd0,
    RS_RS2     = 3'd1,
    RS_RD      = 3'd2,
    RS_LAST    = 3'd3,
    RS_SCRATCH = 3'd4
  } reg_sel_e;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/bus_dp_mem_if.sv
// Memory port tracker: req/ack FSM with wait timeout, write-data capture
// at transaction start and read-data capture on ack (zero on timeout).
module bus_dp_mem_if
  import bus_dp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            op_i,
  input  logic            wr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            ack_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            busy_o,
  output logic            req_o,
  output logic            we_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            tmo_o,
  output mem_state_e      state_o
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  mem_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            we_q;
  logic [XLEN-1:0] wdata_q, rdata_q;
  logic            timeout;

  // cnt_q holds the number of REQ cycles already elapsed without ack.
  assign timeout = (MEM_TIMEOUT != 0) && (state_q == MS_REQ) && !ack_i &&
                   (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= MS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (op_i) state_d = MS_REQ;
      MS_REQ:  if (ack_i || timeout) state_d = MS_DONE;
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    req_o  = 1'b0;
    case (state_q)
      MS_IDLE: busy_o = op_i;
      MS_REQ: begin
        busy_o = 1'b1;
        req_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state_q == MS_IDLE && op_i) begin
      cnt_q   <= '0;
      we_q    <= wr_i;
      wdata_q <= wdata_i;
    end else if (state_q == MS_REQ) begin
      cnt_q <= cnt_q + 1'b1;
      if (ack_i)        rdata_q <= rdata_i;
      else if (timeout) rdata_q <= '0;
    end
  end

  assign we_o    = we_q;
  assign wdata_o = wdata_q;
  assign rdata_o = rdata_q;
  assign tmo_o   = timeout;
  assign state_o = state_q;

endmodule

// File: rtl/bus_datapath_p.sv
// Single shared-bus datapath: IR/A/B/MA, register file with scratch entry,
// ALU and immediate generator, all sourced through one encoded bus mux.
module bus_datapath_p
  import bus_dp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ld_ir,
  input  logic            ld_a,
  input  logic            ld_b,
  input  logic            ld_ma,
  input  logic [2:0]      bus_src,
  input  logic            reg_wr,
  input  logic            mem_wr,
  input  logic [2:0]      reg_sel,
  input  logic [3:0]      alu_op,
  input  logic [1:0]      imm_sel,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            zero,
  output logic            busy,
  output logic            bus_err,
  output mem_state_e      mem_state
);

  localparam int RA = $clog2(NREGS + 1);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] ir_q, a_q, b_q, ma_q;
  logic [XLEN-1:0] rf_q [NREGS+1];
  logic [XLEN-1:0] bus, alu_res, imm, rf_rd, mem_rd;
  logic [31:0]     imm32;
  logic [RA-1:0]   ridx;
  logic            sel_ill, src_ill, wr_bad, mem_op, tmo, err_set, rf_we;
  logic            bus_err_q;

  always_comb begin
    ridx    = '0;
    sel_ill = 1'b0;
    case (reg_sel)
      RS_RS1:     ridx = RA'(ir_q[19:15]);
      RS_RS2:     ridx = RA'(ir_q[24:20]);
      RS_RD:      ridx = RA'(ir_q[11:7]);
      RS_LAST:    ridx = RA'(NREGS - 1);
      RS_SCRATCH: ridx = RA'(NREGS);
      default:    sel_ill = 1'b1;
    endcase
  end

  assign rf_rd = (ridx != '0 && ridx <= RA'(NREGS)) ? rf_q[ridx] : '0;

  always_comb begin
    case (imm_sel)
      IMM_I:   imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      default: imm32 = {ir_q[31:12], 12'b0};
    endcase
  end

  assign imm = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = a_q + b_q;
      ALU_SUB:    alu_res = a_q - b_q;
      ALU_AND:    alu_res = a_q & b_q;
      ALU_OR:     alu_res = a_q | b_q;
      ALU_XOR:    alu_res = a_q ^ b_q;
      ALU_SLL:    alu_res = a_q << b_q[SW-1:0];
      ALU_SRL:    alu_res = a_q >> b_q[SW-1:0];
      ALU_SRA:    alu_res = $signed(a_q) >>> b_q[SW-1:0];
      ALU_SLT:    alu_res = XLEN'($signed(a_q) < $signed(b_q));
      ALU_SLTU:   alu_res = XLEN'(a_q < b_q);
      ALU_PASS_A: alu_res = a_q;
      ALU_PASS_B: alu_res = b_q;
      ALU_ADD4:   alu_res = a_q + XLEN'(4);
      default:    alu_res = '0;
    endcase
  end

  // A cycle carrying both MEM and mem_wr is a write; MEM then reads as zero.
  always_comb begin
    bus     = '0;
    src_ill = 1'b0;
    case (bus_src)
      BUS_NONE: bus = '0;
      BUS_IMM:  bus = imm;
      BUS_ALU:  bus = alu_res;
      BUS_REG:  bus = rf_rd;
      BUS_MEM:  bus = mem_wr ? '0 : mem_rd;
      default:  src_ill = 1'b1;
    endcase
  end

  assign mem_op  = (bus_src == BUS_MEM) || mem_wr;
  assign wr_bad  = reg_wr && (bus_src == BUS_REG);
  assign err_set = src_ill || wr_bad || tmo || ((bus_src == BUS_MEM) && mem_wr) ||
                   (sel_ill && (reg_wr || bus_src == BUS_REG));
  assign rf_we   = !busy && reg_wr && !wr_bad && !sel_ill &&
                   (ridx != '0) && (ridx <= RA'(NREGS));

  bus_dp_mem_if #(
    .XLEN        (XLEN),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_if (
    .clock   (clock),
    .reset_n (reset_n),
    .op_i    (mem_op),
    .wr_i    (mem_wr),
    .wdata_i (bus),
    .ack_i   (mem_ack),
    .rdata_i (mem_rdata),
    .busy_o  (busy),
    .req_o   (mem_req),
    .we_o    (mem_we),
    .wdata_o (mem_wdata),
    .rdata_o (mem_rd),
    .tmo_o   (tmo),
    .state_o (mem_state)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ma_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (!busy) begin
        if (ld_ir) ir_q <= bus;
        if (ld_a)  a_q  <= bus;
        if (ld_b)  b_q  <= bus;
        if (ld_ma) ma_q <= bus;
      end
      if (err_set) bus_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[ridx] <= bus;
    end
  end

  assign mem_addr = ma_q;
  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7   = ir_q[31:25];
  assign zero     = (alu_res == '0);
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_bus_datapath_p.sv
// Directed bench for bus_datapath_p: transfers, ALU/immediates, register
// file rules, memory latency, timeout, error flag and reset mid-request.
module tb_bus_datapath_p;
  import bus_dp_pkg::*;

  logic        clock, reset_n;
  logic        ld_ir, ld_a, ld_b, ld_ma, reg_wr, mem_wr, mem_ack;
  logic [2:0]  bus_src, reg_sel;
  logic [3:0]  alu_op;
  logic [1:0]  imm_sel;
  logic        mem_req, mem_we, zero, busy, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  mem_state_e  mem_state;

  int n_checks = 0;
  int n_pass   = 0;
  int req_n;

  bus_datapath_p #(.XLEN(32), .NREGS(32), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .ld_ir(ld_ir), .ld_a(ld_a), .ld_b(ld_b),
    .ld_ma(ld_ma), .bus_src(bus_src), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .reg_sel(reg_sel), .alu_op(alu_op), .imm_sel(imm_sel), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zero(zero), .busy(busy), .bus_err(bus_err),
    .mem_state(mem_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // driver tasks; every task is entered and left at posedge+1
  task automatic idle();
    ld_ir = 0; ld_a = 0; ld_b = 0; ld_ma = 0; reg_wr = 0; mem_wr = 0;
    bus_src = BUS_NONE; reg_sel = RS_RS1; alu_op = ALU_ADD; imm_sel = IMM_I;
  endtask

  task automatic do_reset();
    idle();
    mem_ack = 0;
    reset_n = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;
  endtask

  task automatic xfer(input logic [2:0] src, input logic [1:0] isel, input logic [3:0] op,
                      input logic [2:0] rsel, input logic [3:0] lds, input logic rw);
    bus_src = src; imm_sel = isel; alu_op = op; reg_sel = rsel;
    {ld_ir, ld_a, ld_b, ld_ma} = lds; reg_wr = rw;
    @(posedge clock); #1;
    idle();
  endtask

  // Observe a bus value by loading it into MA.
  task automatic peek(input string tag, input logic [2:0] src, input logic [1:0] isel,
                      input logic [3:0] op, input logic [2:0] rsel, input logic [31:0] exp);
    xfer(src, isel, op, rsel, 4'b0001, 1'b0);
    check(tag, mem_addr, exp);
  endtask

  task automatic zchk(input string tag, input logic [3:0] op, input logic exp);
    alu_op = op;
    @(negedge clock);
    check(tag, zero, exp);
    @(posedge clock); #1;
    alu_op = ALU_ADD;
  endtask

  // Control word must already be set; ack_at = REQ cycle of the ack (0 = none).
  task automatic mem_txn(input string tag, input int ack_at, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic exp_we,
                         input logic chk_wd, input logic [31:0] exp_wd, input logic [6:0] exp_op0);
    int n;
    @(negedge clock);
    check({tag, "_busy_c0"}, busy, 1'b1);
    check({tag, "_req_c0"}, mem_req, 1'b0);
    @(posedge clock); #1;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      if (n == ack_at) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      @(negedge clock);
      check({tag, "_busy_req"}, busy, 1'b1);
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_we"}, mem_we, exp_we);
      if (chk_wd) check({tag, "_wdata"}, mem_wdata, exp_wd);
      check({tag, "_ir_hold"}, opcode, exp_op0);
      @(posedge clock); #1;
      mem_ack = 0;
    end
    req_n = n;
    @(negedge clock);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_ir_hold_done"}, opcode, exp_op0);
    @(posedge clock); #1;
    idle();
  endtask

  task automatic mem_load_ir(input string tag, input int ack_at, input logic [31:0] val,
                             input logic [31:0] exp_addr, input logic [6:0] exp_op0);
    bus_src = BUS_MEM; ld_ir = 1;
    mem_txn(tag, ack_at, val, exp_addr, 1'b0, 1'b0, 32'h0, exp_op0);
  endtask

  // ALU table with A = 0xFFFFFFFF, B = 3
  logic [31:0] alu_exp [16] = '{32'h2, 32'hFFFFFFFC, 32'h3, 32'hFFFFFFFF,
                                32'hFFFFFFFC, 32'hFFFFFFF8, 32'h1FFFFFFF, 32'hFFFFFFFF,
                                32'h1, 32'h0, 32'hFFFFFFFF, 32'h3, 32'h3,
                                32'h0, 32'h0, 32'h0};

  initial begin
    mem_rdata = 0;
    do_reset();
    check("rst_opcode", opcode, 7'h0);
    check("rst_ma", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", bus_err, 1'b0);
    check("rst_state", mem_state, MS_IDLE);
    zchk("rst_zero", ALU_ADD, 1'b1);

    // IR = addi x1,x0,-1; A,B <- I-imm; x1 <- A+B
    mem_load_ir("ir1", 1, 32'hFFF00093, 32'h0, 7'h0);
    check("ir1_req_n", req_n, 1);
    check("ir1_opcode", opcode, 7'h13);
    check("ir1_funct3", funct3, 3'h0);
    check("ir1_funct7", funct7, 7'h7F);
    xfer(BUS_IMM, IMM_I, ALU_ADD, RS_RS1, 4'b0100, 1'b0);
    xfer(BUS_IMM, IMM_I, ALU_ADD, RS_RS1, 4'b0010, 1'b0);
    zchk("add_zero", ALU_ADD, 1'b0);
    zchk("sub_zero", ALU_SUB, 1'b1);
    xfer(BUS_ALU, IMM_I, ALU_ADD, RS_RD, 4'b0000, 1'b1);
    peek("x1_read", BUS_REG, IMM_I, ALU_ADD, RS_RD, 32'hFFFFFFFE);
    peek("imm_i", BUS_IMM, IMM_I, ALU_ADD, RS_RS1, 32'hFFFFFFFF);
    peek("imm_s", BUS_IMM, IMM_S, ALU_ADD, RS_RS1, 32'hFFFFFFE1);
    peek("imm_b", BUS_IMM, IMM_B, ALU_ADD, RS_RS1, 32'hFFFFFFE0);
    peek("imm_u", BUS_IMM, IMM_U, ALU_ADD, RS_RS1, 32'hFFF00000);

    xfer(BUS_ALU, IMM_I, ALU_ADD4, RS_RS1, 4'b0010, 1'b0);
    for (int i = 0; i < 16; i++)
      peek($sformatf("alu_op%0d", i), BUS_ALU, IMM_I, 4'(i), RS_RS1, alu_exp[i]);
    check("no_err_yet", bus_err, 1'b0);

    // MA <- 0x100, then a read with ack on the third REQ cycle
    mem_load_ir("ir2", 2, 32'h10000013, 32'h0, 7'h13);
    peek("ma_100", BUS_IMM, IMM_I, ALU_ADD, RS_RS1, 32'h100);
    mem_load_ir("rd3", 3, 32'h40208133, 32'h100, 7'h13);
    check("rd3_req_n", req_n, 3);
    check("rd3_opcode", opcode, 7'h33);
    check("rd3_funct7", funct7, 7'h20);

    // x2 <- 0xDEADBEEF from memory, then write x2 out with ack in cycle 1
    bus_src = BUS_MEM; reg_sel = RS_RD; reg_wr = 1;
    mem_txn("x2ld", 1, 32'hDEADBEEF, 32'h100, 1'b0, 1'b0, 32'h0, 7'h33);
    bus_src = BUS_REG; reg_sel = RS_RD; mem_wr = 1;
    mem_txn("wr", 1, 32'h0, 32'h100, 1'b1, 1'b1, 32'hDEADBEEF, 7'h33);
    check("wr_req_n", req_n, 1);
    check("wr_no_err", bus_err, 1'b0);

    // timeout: no ack
    mem_load_ir("tmo", 0, 32'h0, 32'h100, 7'h33);
    check("tmo_req_n", req_n, 4);
    check("tmo_err", bus_err, 1'b1);
    check("tmo_opcode", opcode, 7'h0);
    check("tmo_funct7", funct7, 7'h0);
    do_reset();
    check("rst2_err", bus_err, 1'b0);

    // x0 write dropped, x31 and scratch hold values
    mem_load_ir("ir3", 2, 32'h00500013, 32'h0, 7'h0);
    check("ir3_req_n", req_n, 2);
    xfer(BUS_IMM, IMM_I, ALU_ADD, RS_RD, 4'b0000, 1'b1);
    peek("x0_read", BUS_REG, IMM_I, ALU_ADD, RS_RD, 32'h0);
    xfer(BUS_IMM, IMM_I, ALU_ADD, RS_LAST, 4'b0000, 1'b1);
    peek("x31_read", BUS_REG, IMM_I, ALU_ADD, RS_LAST, 32'h5);
    xfer(BUS_ALU, IMM_I, ALU_ADD4, RS_SCRATCH, 4'b0000, 1'b1);
    peek("scratch_read", BUS_REG, IMM_I, ALU_ADD, RS_SCRATCH, 32'h4);
    check("rf_no_err", bus_err, 1'b0);

    // stray ack while idle
    mem_ack = 1;
    @(posedge clock); #1;
    mem_ack = 0;
    check("stray_ack_state", mem_state, MS_IDLE);
    check("stray_ack_req", mem_req, 1'b0);

    // illegal bus_src: bus 0, error sticky
    peek("ill_src_bus", 3'd6, IMM_I, ALU_ADD, RS_RS1, 32'h0);
    check("ill_src_err", bus_err, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("err_sticky", bus_err, 1'b1);
    do_reset();
    check("rst3_err", bus_err, 1'b0);

    xfer(BUS_REG, IMM_I, ALU_ADD, RS_LAST, 4'b0000, 1'b1);
    check("regwr_reg_err", bus_err, 1'b1);
    do_reset();
    peek("ill_sel_bus", BUS_REG, IMM_I, ALU_ADD, 3'd5, 32'h0);
    check("ill_sel_err", bus_err, 1'b1);
    do_reset();

    // MEM together with mem_wr is a write of zero
    bus_src = BUS_MEM; mem_wr = 1;
    mem_txn("conf", 1, 32'h12345678, 32'h0, 1'b1, 1'b1, 32'h0, 7'h0);
    check("conf_err", bus_err, 1'b1);
    do_reset();

    // reset asserted during REQ
    bus_src = BUS_MEM; ld_ir = 1;
    @(posedge clock); #1;
    check("mid_req_up", mem_req, 1'b1);
    idle();
    #2 reset_n = 0;
    #1;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_state", mem_state, MS_IDLE);
    check("mid_rst_busy", busy, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock); #1;
    mem_load_ir("post_rst", 2, 32'h00000033, 32'h0, 7'h0);
    check("post_rst_req_n", req_n, 2);
    check("post_rst_opcode", opcode, 7'h33);
    check("post_rst_err", bus_err, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_datapath_p.md
# bus_datapath_p

Parametrised successor of the team's single-bus RISC-V microcoded datapath. It holds IR, A, B, MA and the register file. All transfers go over one internal shared bus whose source comes from an encoded select, so two drivers can never contend. Memory is an external req/ack port with a tracking FSM, a timeout, and a stall that freezes all state updates. The microcoded control unit drives the control inputs and consumes the decode, zero and busy outputs.

## Interface
- XLEN, 32: datapath width; ≥32.
- NREGS, 32: architectural registers; file holds NREGS+1 entries (index NREGS = scratch); RA = $clog2(NREGS+1).
- MEM_TIMEOUT, 255: max cycles waiting for mem_ack; 0 disables timeout.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_ir, ld_a, ld_b, ld_ma  in  1 each  load register from bus at clock edge.
- bus_src  in  3  0 NONE, 1 IMM, 2 ALU, 3 REG, 4 MEM; 5–7 illegal.
- reg_wr  in  1  write bus into register file at selected index.
- mem_wr  in  1  start memory write of current bus value to address MA.
- reg_sel  in  3  0 rs1, 1 rs2, 2 rd, 3 index NREGS-1, 4 scratch NREGS; 5–7 illegal.
- alu_op  in  4  see Operation.
- imm_sel  in  2  0 I, 1 S, 2 B, 3 U.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write qualifier, valid with mem_req.
- mem_addr  out  XLEN  = MA.
- mem_wdata  out  XLEN  captured bus value.
- mem_rdata  in  XLEN  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- opcode / funct3 / funct7  out  7/3/7  IR[6:0] / IR[14:12] / IR[31:25].
- zero  out  1  ALU result == 0.
- busy  out  1  memory transaction in progress; control word must be held.
- bus_err  out  1  sticky error flag; cleared only by reset.

## Operation
- Bus is combinational from bus_src:
  - IMM: sign-extended immediate from IR.
  - ALU: ALU result.
  - REG: register file read at reg_sel; index 0 reads 0.
  - MEM: captured read data.
  - NONE or illegal: bus = 0.
- ALU on A, B:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
  - 8 SLT, 9 SLTU, 10 PASS_A, 11 PASS_B, 12 A+4; 13–15 → 0.
  - Shift amount is B[$clog2(XLEN)-1:0].
- Immediates: I = IR[31:20]; S = {IR[31:25],IR[11:7]}; B = {IR[31],IR[7],IR[30:25],IR[11:8],0}; U = {IR[31:12],12'b0}. All are sign-extended to XLEN.
- Register file writes to index 0 are dropped.
- A memory op is bus_src==MEM or mem_wr==1. A cycle carrying both is a write; MEM then reads as 0 and bus_err is set.
- Memory FSM states:
  - IDLE: a memory op → REQ. Capture mem_wdata = bus and mem_we = mem_wr; busy = 1 in this cycle.
  - REQ: mem_req = 1, busy = 1. On mem_ack → DONE and capture mem_rdata. On timeout → DONE, capture 0, set bus_err.
  - DONE: busy = 0, bus MEM shows the captured data, loads commit at the end of this cycle → IDLE.
    - The memory op still on the control word in DONE does not start a new transaction.
- ld_*, reg_wr are ignored in every cycle where busy = 1.
- bus_err is also set by illegal bus_src, illegal reg_sel, or reg_wr with bus_src==REG (that write is suppressed).

## Timing
- Reset values: IR, A, B, MA, all registers, mem_wdata = 0; FSM IDLE; mem_req, mem_we, busy, bus_err = 0. Reset mid-transaction drops mem_req immediately.
- Non-memory transfers are single-cycle: the source drives the bus, and the destination loads at the same rising edge.
- Memory latency (op presented in cycle 0):
  - mem_req rises in cycle 1.
  - With ack in cycle k ≥ 1, DONE is in cycle k+1 and the load commits at the end of cycle k+1.
  - Minimum is 3 cycles.
- mem_addr and mem_we stay stable while mem_req = 1. An ack outside REQ is ignored.
- Timeout fires when the wait counter reaches MEM_TIMEOUT cycles in REQ without ack.
- zero, opcode and the decode fields are combinational from A, B, IR.

## Structure
- Shared package `bus_dp_pkg`: bus_src, alu_op, imm_sel, reg_sel encodings and the FSM state enum.
- Natural sub-module `bus_dp_mem_if`: FSM, timeout counter, data capture; outputs busy, mem_req, mem_we, mem_wdata, captured read data, timeout error pulse.
- ALU, immediate generator and register file stay inline in the top level.

## Test plan
- Reset, then A←IMM (I, IR=0xFFF00093), B←IMM, ADD, x1←ALU → x1 reads 0xFFFFFFFE; zero=0.
- MA←0x100, bus_src=MEM, ld_ir, ack on 3rd REQ cycle → busy high 4 cycles; IR = mem_rdata after DONE; no earlier IR change.
- mem_wr with bus = x2 = 0xDEADBEEF, ack in cycle 1 → mem_we=1, mem_wdata=0xDEADBEEF, mem_addr=MA, busy low by cycle 2.
- MEM_TIMEOUT=4, no ack → mem_req high 4 cycles, bus_err=1, IR loads 0.
- reg_wr x0←0x5 then read x0 → 0. bus_src=6 → bus 0, bus_err sticky until reset.
- reset_n low during REQ → mem_req=0 in the same cycle, FSM IDLE, a later op proceeds normally.
